// File: rtl/vending_pkg.sv
// Shared definitions for the multi-product vending machine: coin values,
// FSM state encoding and a helper that pulls one price out of a packed vector.
package vending_pkg;

    localparam int NICKEL_C  = 5;
    localparam int DIME_C    = 10;
    localparam int QUARTER_C = 25;

    // Widest price / largest product count the price helper can unpack.
    localparam int PRICE_MAX_W = 16;
    localparam int PRICE_MAX_N = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_e;

    // Returns price number idx from a packed price vector whose fields are cw
    // bits wide. Shifting left then right clears every bit above the field.
    function automatic logic [PRICE_MAX_W-1:0] price_of(
        input logic [PRICE_MAX_N*PRICE_MAX_W-1:0] prices,
        input int                                 idx,
        input int                                 cw
    );
        logic [PRICE_MAX_W-1:0] r;
        r = PRICE_MAX_W'(prices >> (idx * cw));
        r = r << (PRICE_MAX_W - cw);
        r = r >> (PRICE_MAX_W - cw);
        return r;
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// Greedy coin selector: for a given credit picks the largest coin that fits.
// Used for both refunds and change after a sale.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [2:0]          coin_qdn,
    output logic [CREDIT_W-1:0] coin_val
);

    localparam logic [CREDIT_W-1:0] QV = CREDIT_W'(QUARTER_C);
    localparam logic [CREDIT_W-1:0] DV = CREDIT_W'(DIME_C);
    localparam logic [CREDIT_W-1:0] NV = CREDIT_W'(NICKEL_C);

    // Pick quarter, else dime, else nickel; nothing when credit is empty.
    always_comb begin
        coin_qdn = 3'b000;
        coin_val = {CREDIT_W{1'b0}};
        if (credit >= QV) begin
            coin_qdn = 3'b100;
            coin_val = QV;
        end else if (credit >= DV) begin
            coin_qdn = 3'b010;
            coin_val = DV;
        end else if (credit != {CREDIT_W{1'b0}}) begin
            coin_qdn = 3'b001;
            coin_val = NV;
        end else begin
            coin_qdn = 3'b000;
            coin_val = {CREDIT_W{1'b0}};
        end
    end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: accumulates coin credit, sells one of
// NUM_PRODUCTS items and pays change/refunds as one coin pulse per cycle.
module vending_machine_multi
    import vending_pkg::*;
#(
    parameter int                            NUM_PRODUCTS = 4,
    parameter int                            SEL_W        = 2,
    parameter int                            CREDIT_W     = 8,
    parameter int                            MAX_CREDIT   = 100,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES    = {8'd65, 8'd50, 8'd35, 8'd25}
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                N,
    input  logic                D,
    input  logic                Q,
    input  logic [SEL_W-1:0]    Sel,
    input  logic                Buy,
    input  logic                Cancel,
    output logic                Candy,
    output logic [SEL_W-1:0]    VendSel,
    output logic [CREDIT_W-1:0] Credit,
    output logic                RetQ,
    output logic                RetD,
    output logic                RetN,
    output logic                Busy,
    output logic                Reject,
    output logic                Short
);

    localparam int NUM_SLOTS = 1 << SEL_W;
    localparam logic [CREDIT_W:0] MAX_C_W = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [PRICE_MAX_N*PRICE_MAX_W-1:0] PRICES_EXT =
        (PRICE_MAX_N * PRICE_MAX_W)'(PRICES);

    // ---------------- elaboration-time parameter checks ----------------
    if (NUM_PRODUCTS < 1 || NUM_PRODUCTS > PRICE_MAX_N) begin : g_bad_num
        $error("NUM_PRODUCTS out of range 1..16");
    end
    if (CREDIT_W < 1 || CREDIT_W > PRICE_MAX_W) begin : g_bad_cw
        $error("CREDIT_W out of supported range");
    end
    if (NUM_SLOTS < NUM_PRODUCTS) begin : g_bad_sel
        $error("SEL_W too narrow for NUM_PRODUCTS");
    end
    if ((MAX_CREDIT % 5) != 0 || MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_max
        $error("MAX_CREDIT must be a multiple of 5 below 2**CREDIT_W");
    end

    // Price table indexed directly by Sel; unused slots are marked invalid.
    logic [CREDIT_W-1:0] price_tbl [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_valid;

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        if (gi < NUM_PRODUCTS) begin : g_prod
            localparam int P = int'(price_of(PRICES_EXT, gi, CREDIT_W));
            if (P == 0 || (P % 5) != 0 || P > MAX_CREDIT) begin : g_bad_price
                $error("price must be a nonzero multiple of 5 not above MAX_CREDIT");
            end
            assign price_tbl[gi]  = CREDIT_W'(P);
            assign slot_valid[gi] = 1'b1;
        end else begin : g_empty
            assign price_tbl[gi]  = {CREDIT_W{1'b0}};
            assign slot_valid[gi] = 1'b0;
        end
    end

    // ---------------- state and output registers ----------------
    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                candy_q, candy_d;
    logic [SEL_W-1:0]    vend_sel_q, vend_sel_d;
    logic [2:0]          ret_q, ret_d;
    logic                busy_q, busy_d;
    logic                reject_q, reject_d;
    logic                short_q, short_d;

    // ---------------- combinational helpers ----------------
    logic [2:0]          disp_qdn_s;
    logic [CREDIT_W-1:0] disp_val_s;
    logic [CREDIT_W-1:0] credit_left_s;
    logic [CREDIT_W-1:0] coin_val_s;
    logic                coin_one_s;
    logic                coin_any_s;
    logic [CREDIT_W:0]   coin_sum_s;
    logic [CREDIT_W-1:0] sel_price_s;
    logic                buy_ok_s;

    change_dispenser #(
        .CREDIT_W (CREDIT_W)
    ) u_change (
        .credit   (credit_q),
        .coin_qdn (disp_qdn_s),
        .coin_val (disp_val_s)
    );

    // Decode the coin inputs and evaluate the purchase request.
    always_comb begin
        coin_any_s = N | D | Q;
        case ({Q, D, N})
            3'b001: begin
                coin_one_s = 1'b1;
                coin_val_s = CREDIT_W'(NICKEL_C);
            end
            3'b010: begin
                coin_one_s = 1'b1;
                coin_val_s = CREDIT_W'(DIME_C);
            end
            3'b100: begin
                coin_one_s = 1'b1;
                coin_val_s = CREDIT_W'(QUARTER_C);
            end
            default: begin
                coin_one_s = 1'b0;
                coin_val_s = {CREDIT_W{1'b0}};
            end
        endcase
        coin_sum_s    = {1'b0, credit_q} + {1'b0, coin_val_s};
        sel_price_s   = price_tbl[Sel];
        buy_ok_s      = slot_valid[Sel] && ({1'b0, credit_q} >= {1'b0, sel_price_s});
        credit_left_s = credit_q - disp_val_s;
    end

    // Next-state and next-output logic for the IDLE/VEND/CHANGE controller.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        candy_d    = 1'b0;
        vend_sel_d = {SEL_W{1'b0}};
        ret_d      = 3'b000;
        reject_d   = 1'b0;
        short_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Cancel) begin
                    reject_d = coin_any_s;
                    if (credit_q != {CREDIT_W{1'b0}}) begin
                        ret_d    = disp_qdn_s;
                        credit_d = credit_left_s;
                        state_d  = (credit_left_s == {CREDIT_W{1'b0}}) ? IDLE : CHANGE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (Buy) begin
                    reject_d = coin_any_s;
                    if (buy_ok_s) begin
                        state_d    = VEND;
                        candy_d    = 1'b1;
                        vend_sel_d = Sel;
                        credit_d   = credit_q - sel_price_s;
                    end else begin
                        short_d = 1'b1;
                    end
                end else if (coin_any_s) begin
                    if (coin_one_s && (coin_sum_s <= MAX_C_W)) begin
                        credit_d = coin_sum_s[CREDIT_W-1:0];
                    end else begin
                        reject_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            VEND, CHANGE: begin
                // Change paying starts straight out of VEND so the first
                // coin appears two cycles after Buy.
                reject_d = coin_any_s;
                if (credit_q != {CREDIT_W{1'b0}}) begin
                    ret_d    = disp_qdn_s;
                    credit_d = credit_left_s;
                    state_d  = (credit_left_s == {CREDIT_W{1'b0}}) ? IDLE : CHANGE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = {CREDIT_W{1'b0}};
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Register state and all outputs; synchronous reset clears everything.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            credit_q   <= {CREDIT_W{1'b0}};
            candy_q    <= 1'b0;
            vend_sel_q <= {SEL_W{1'b0}};
            ret_q      <= 3'b000;
            busy_q     <= 1'b0;
            reject_q   <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            candy_q    <= candy_d;
            vend_sel_q <= vend_sel_d;
            ret_q      <= ret_d;
            busy_q     <= busy_d;
            reject_q   <= reject_d;
            short_q    <= short_d;
        end
    end

    assign Candy   = candy_q;
    assign VendSel = vend_sel_q;
    assign Credit  = credit_q;
    assign RetQ    = ret_q[2];
    assign RetD    = ret_q[1];
    assign RetN    = ret_q[0];
    assign Busy    = busy_q;
    assign Reject  = reject_q;
    assign Short   = short_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Self-checking bench for vending_machine_multi: a transaction-level model
// (credit as an integer plus a queue of upcoming output events) is compared
// with the DUT every cycle; directed scenarios pin the model with literals.
module tb_vending_machine_multi;

    logic       Clk = 1'b0;
    logic       Rst, N, D, Q, Buy, Cancel;
    logic [1:0] Sel;
    logic       Candy;
    logic [1:0] VendSel;
    logic [7:0] Credit;
    logic       RetQ, RetD, RetN, Busy, Reject, Short;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 Clk = ~Clk;

    vending_machine_multi dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .N       (N),
        .D       (D),
        .Q       (Q),
        .Sel     (Sel),
        .Buy     (Buy),
        .Cancel  (Cancel),
        .Candy   (Candy),
        .VendSel (VendSel),
        .Credit  (Credit),
        .RetQ    (RetQ),
        .RetD    (RetD),
        .RetN    (RetN),
        .Busy    (Busy),
        .Reject  (Reject),
        .Short   (Short)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit candy;
        int vsel;
        int ret;
        int credit;
    } ev_t;

    ev_t evq[$];
    int  price [4] = '{25, 35, 50, 65};
    int  m_credit = 0;
    bit  e_candy, e_rej, e_short, e_busy;
    int  e_vsel, e_ret;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Greedy decomposition by plain division: quarters, then dimes, then nickels.
    function automatic void push_change(input int c);
        int left;
        int nq, nd, nn;
        left = c;
        nq = c / 25;
        nd = (c % 25) / 10;
        nn = ((c % 25) % 10) / 5;
        for (int i = 0; i < nq; i++) begin left -= 25; evq.push_back('{1'b0, 0, 25, left}); end
        for (int i = 0; i < nd; i++) begin left -= 10; evq.push_back('{1'b0, 0, 10, left}); end
        for (int i = 0; i < nn; i++) begin left -= 5;  evq.push_back('{1'b0, 0, 5,  left}); end
    endfunction

    always @(posedge Clk) begin
        int cnt, val, s;
        ev_t e;
        cnt = int'(N) + int'(D) + int'(Q);
        s   = int'(Sel);
        e_candy = 1'b0; e_vsel = 0; e_ret = 0; e_rej = 1'b0; e_short = 1'b0;
        if (Rst) begin
            evq.delete();
            m_credit = 0;
            e_busy   = 1'b0;
        end else begin
            if (evq.size() == 0) begin
                if (Cancel) begin
                    e_rej = (cnt > 0);
                    if (m_credit > 0) push_change(m_credit);
                end else if (Buy) begin
                    e_rej = (cnt > 0);
                    if (s < 4 && m_credit >= price[s]) begin
                        m_credit -= price[s];
                        evq.push_back('{1'b1, s, 0, m_credit});
                        if (m_credit > 0) push_change(m_credit);
                        else evq.push_back('{1'b0, 0, 0, 0});
                    end else begin
                        e_short = 1'b1;
                    end
                end else if (cnt == 1) begin
                    val = N ? 5 : (D ? 10 : 25);
                    if (m_credit + val <= 100) m_credit += val;
                    else e_rej = 1'b1;
                end else if (cnt > 1) begin
                    e_rej = 1'b1;
                end
            end else begin
                e_rej = (cnt > 0);
            end
            if (evq.size() > 0) begin
                e = evq.pop_front();
                e_candy  = e.candy;
                e_vsel   = e.vsel;
                e_ret    = e.ret;
                m_credit = e.credit;
            end
            e_busy = (evq.size() > 0);
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("Candy", Candy, e_candy);
            if (e_candy) chk("VendSel", VendSel, e_vsel);
            chk("Credit", Credit, m_credit);
            chk("RetQ", RetQ, e_ret == 25);
            chk("RetD", RetD, e_ret == 10);
            chk("RetN", RetN, e_ret == 5);
            chk("Busy", Busy, e_busy);
            chk("Reject", Reject, e_rej);
            chk("Short", Short, e_short);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit n, input bit d, input bit q, input int sel,
                        input bit buy, input bit cancel, input bit rst);
        N = n; D = d; Q = q; Sel = 2'(sel); Buy = buy; Cancel = cancel; Rst = rst;
        @(negedge Clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic coin_q(); step(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0); endtask
    task automatic coin_d(); step(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0); endtask
    task automatic coin_n(); step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0); endtask

    initial begin
        N = 1'b0; D = 1'b0; Q = 1'b0; Sel = 2'd0; Buy = 1'b0; Cancel = 1'b0; Rst = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        chk_en = 1'b1;
        chk("rst_credit", Credit, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_candy", Candy, 0);

        // Q + D buys product 1 (35) exactly.
        coin_q(); coin_d();
        step(1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        chk("s1_candy", Candy, 1); chk("s1_vsel", VendSel, 1); chk("s1_credit", Credit, 0);
        idle();
        chk("s1_busy", Busy, 0); chk("s1_noret", {RetQ, RetD, RetN}, 0);

        // Two quarters buy product 0 (25): one quarter change.
        coin_q(); coin_q();
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("s2_candy", Candy, 1); chk("s2_credit", Credit, 25);
        idle();
        chk("s2_retq", RetQ, 1); chk("s2_credit0", Credit, 0);

        // Fill to 100, overflow nickel, then refund four quarters.
        repeat (4) coin_q();
        chk("s3_full", Credit, 100);
        coin_n();
        chk("s3_reject", Reject, 1); chk("s3_hold", Credit, 100);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("s3_q0", RetQ, 1);
        for (int i = 1; i < 4; i++) begin idle(); chk("s3_qn", RetQ, 1); end
        chk("s3_end", Credit, 0);

        // 40 refunded as Q, D, N.
        coin_q(); coin_d(); coin_n();
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("s4_q", RetQ, 1); chk("s4_c15", Credit, 15);
        idle(); chk("s4_d", RetD, 1); chk("s4_c5", Credit, 5);
        idle(); chk("s4_n", RetN, 1); chk("s4_c0", Credit, 0);

        // Short on product 3, then Buy with a dime in the same cycle.
        coin_q();
        step(1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0);
        chk("s5_short", Short, 1); chk("s5_credit", Credit, 25);
        step(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("s5_candy", Candy, 1); chk("s5_rej", Reject, 1); chk("s5_credit0", Credit, 0);
        idle();

        // Reset in the middle of paying change.
        coin_q(); coin_q(); coin_d(); coin_n();
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("s6_credit40", Credit, 40);
        idle(); chk("s6_retq", RetQ, 1);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("s6_rst_credit", Credit, 0); chk("s6_rst_busy", Busy, 0);
        idle(); chk("s6_noret", {RetQ, RetD, RetN}, 0);

        // Cancel with no credit, double coin.
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("s7_idle", Busy, 0);
        step(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("s7_dbl_rej", Reject, 1);

        // Randomised traffic checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            int r;
            bit n, d, q;
            r = $urandom_range(0, 99);
            n = (r < 15) || (r >= 45 && r < 48);
            d = (r >= 15 && r < 30) || (r >= 45 && r < 48);
            q = (r >= 30 && r < 45);
            step(n, d, q, $urandom_range(0, 3),
                 $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 299) < 2);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
